// File: rtl/dcache_if.sv
// Core-side and memory-side signal bundle for the data cache.
// slave = cache side, master = core/memory side (testbench).
interface dcache_if;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    modport slave (
        input  dcache_addr, dcache_re, dcache_we, dcache_din,
        output dcache_dout, stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output dcache_addr, dcache_re, dcache_we, dcache_din,
        input  dcache_dout, stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/dcache_controller.sv
// Blocking direct-mapped, write-through, no-write-allocate data cache.
// One outstanding memory operation; the core is frozen via stall while it is in flight.
module dcache_controller #(
    parameter int LINES = 64
) (
    input  logic     clk,
    input  logic     reset,
    dcache_if.slave  bus
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

    logic [127:0]     data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    state_e      state_q, state_d;
    logic [31:0] dout_q, dout_d;
    logic [31:2] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] din_q, din_d;
    logic        skip_q, skip_d;
    logic        refill, wr_merge;

    // Lookup on the live core address (IDLE) and on the latched address (WR_REQ)
    logic [INDEX_W-1:0] idx_in, idx_q;
    logic [TAG_W-1:0]   tag_in, tag_lat;
    logic [1:0]         off_in, off_q;
    logic               hit_in, hit_lat;
    logic [31:0]        rd_word;
    logic [1:0]         unused_addr_bits;

    assign idx_in   = bus.dcache_addr[INDEX_W+3:4];
    assign tag_in   = bus.dcache_addr[31:INDEX_W+4];
    assign off_in   = bus.dcache_addr[3:2];
    assign idx_q    = addr_q[INDEX_W+3:4];
    assign tag_lat  = addr_q[31:INDEX_W+4];
    assign off_q    = addr_q[3:2];
    assign hit_in   = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
    assign hit_lat  = valid_q[idx_q] && (tag_q[idx_q] == tag_lat);
    assign rd_word  = data_q[idx_in][{off_in, 5'b0} +: 32];
    assign unused_addr_bits = bus.dcache_addr[1:0];

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        addr_d   = addr_q;
        we_d     = we_q;
        din_d    = din_q;
        skip_d   = 1'b0;
        refill   = 1'b0;
        wr_merge = 1'b0;
        case (state_q)
            IDLE: begin
                // Core still presents the just-completed request here; drop it
                if (!skip_q) begin
                    if (bus.dcache_we != 4'b0) begin
                        addr_d  = bus.dcache_addr[31:2];
                        we_d    = bus.dcache_we;
                        din_d   = bus.dcache_din;
                        state_d = WR_REQ;
                    end else if (bus.dcache_re) begin
                        if (hit_in) begin
                            dout_d = rd_word;
                        end else begin
                            addr_d  = bus.dcache_addr[31:2];
                            we_d    = 4'b0;
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (bus.mem_req_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_resp_valid) begin
                    refill  = 1'b1;
                    dout_d  = bus.mem_resp_data[{off_q, 5'b0} +: 32];
                    skip_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (bus.mem_req_ready) begin
                    wr_merge = hit_lat;
                    skip_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dout_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            din_q   <= '0;
            skip_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            skip_q  <= skip_d;
            if (refill) valid_q[idx_q] <= 1'b1;
        end
    end

    // Tag/data storage is not reset; valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (refill) begin
            data_q[idx_q] <= bus.mem_resp_data;
            tag_q[idx_q]  <= tag_lat;
        end else if (wr_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (we_q[b]) data_q[idx_q][{off_q, 2'(b), 3'b000} +: 8] <= din_q[8*b +: 8];
            end
        end
    end

    assign bus.dcache_dout   = dout_q;
    assign bus.stall         = (state_q != IDLE);
    assign bus.mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus.mem_req_rw    = (state_q == WR_REQ);
    assign bus.mem_req_addr  = addr_q[31:4];
    assign bus.mem_req_data  = {4{din_q}};
    assign bus.mem_req_mask  = (state_q == WR_REQ) ? ({12'b0, we_q} << {off_q, 2'b00}) : 16'h0;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: memory-request and read-data scoreboards
// fed by the stimulus tasks, drained by independent monitor processes.
module tb_dcache_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus();
    dcache_controller #(.LINES(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic         rw;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    event        rd_ev;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    int          ready_delay = 0;
    int          resp_delay = 3;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        if (la == 28'h0000100) return {32'hD, 32'hC, 32'hB, 32'hA};
        for (int w = 0; w < 4; w++) l[32*w +: 32] = {la, 4'(w)};
        return l;
    endfunction

    // Memory model: ready after ready_delay cycles of valid, refill resp_delay cycles after accept
    initial begin
        int          rdy_cnt = 0;
        int          resp_cnt = 0;
        logic        acc_rw = 1'b0;
        logic [27:0] acc_addr = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (bus.mem_req_ready) begin
                bus.mem_req_ready = 1'b0;
                if (!acc_rw) resp_cnt = resp_delay;
            end else if (bus.mem_req_valid) begin
                if (rdy_cnt >= ready_delay) begin
                    bus.mem_req_ready = 1'b1;
                    acc_rw   = bus.mem_req_rw;
                    acc_addr = bus.mem_req_addr;
                    rdy_cnt  = 0;
                end else rdy_cnt++;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = mem_line(acc_addr);
                end
            end
        end
    end

    // Request monitor: every accepted memory request must match the next expectation
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_req: got rw=%0b addr=%0h, no request expected",
                             bus.mem_req_rw, bus.mem_req_addr);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_rw", bus.mem_req_rw, e.rw);
                    chk("req_addr", bus.mem_req_addr, e.addr);
                    chk("req_mask", bus.mem_req_mask, e.mask);
                    if (e.rw) chk("req_data", bus.mem_req_data, e.data);
                end
            end
        end
    end

    // Read-data monitor
    initial begin
        forever begin
            @(rd_ev);
            if (exp_rd.size() != 0) chk("dout", bus.dcache_dout, exp_rd.pop_front());
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.stall && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.stall) begin
            total_cnt++;
            $display("FAIL stall_timeout: stall still %0b after %0d cycles", bus.stall, n);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic miss, input logic [31:0] exp_d,
                           output int lat);
        @(negedge clk);
        bus.dcache_addr = a;
        bus.dcache_re   = 1'b1;
        bus.dcache_we   = 4'b0;
        if (miss) exp_req.push_back('{1'b0, a[31:4], 128'h0, 16'h0});
        @(negedge clk);
        chk("rd_stall", bus.stall, miss);
        if (!miss) chk("hit_no_req", bus.mem_req_valid, 1'b0);
        wait_idle(lat);
        exp_rd.push_back(exp_d);
        ->rd_ev;
        if (miss) @(negedge clk);
        bus.dcache_re = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                            input logic [15:0] exp_mask, input int rdly);
        int n;
        ready_delay = rdly;
        @(negedge clk);
        bus.dcache_addr = a;
        bus.dcache_we   = we;
        bus.dcache_din  = din;
        bus.dcache_re   = 1'b0;
        exp_req.push_back('{1'b1, a[31:4], {4{din}}, exp_mask});
        @(negedge clk);
        chk("st_stall", bus.stall, 1'b1);
        wait_idle(n);
        chk("st_accept_lat", n, rdly + 1);
        @(negedge clk);
        bus.dcache_we = 4'b0;
        ready_delay = 0;
    endtask

    initial begin
        int lat;
        bus.dcache_addr = '0;
        bus.dcache_re   = 1'b0;
        bus.dcache_we   = 4'b0;
        bus.dcache_din  = '0;

        repeat (3) @(negedge clk);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_dout", bus.dcache_dout, 32'h0);
        reset = 1'b1;

        // 1: cold miss, stall spans request + 3-cycle refill
        do_read(32'h0000_1004, 1'b1, 32'h0000_000B, lat);
        chk("miss_latency", lat, 4);
        // 2: hit, no stall
        do_read(32'h0000_1008, 1'b0, 32'h0000_000C, lat);
        // 3: store hit with ready held low 2 cycles, then byte merge visible
        do_store(32'h0000_1004, 4'b0011, 32'h1234_5678, 16'h0030, 2);
        do_read(32'h0000_1004, 1'b0, 32'h0000_5678, lat);
        // 4: store miss does not allocate or disturb the resident line
        do_store(32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 16'h000F, 0);
        do_read(32'h0000_1004, 1'b0, 32'h0000_5678, lat);
        do_read(32'h0000_2000, 1'b1, 32'h0000_2000, lat);
        // 5: index conflict evictions
        do_read(32'h0000_1000, 1'b1, 32'h0000_000A, lat);
        do_read(32'h0000_1400, 1'b1, 32'h0000_1400, lat);
        do_read(32'h0000_1000, 1'b1, 32'h0000_000A, lat);

        // 6: reset during RD_WAIT, late response must be dropped
        @(negedge clk);
        bus.dcache_addr = 32'h0000_3000;
        bus.dcache_re   = 1'b1;
        exp_req.push_back('{1'b0, 28'h0000300, 128'h0, 16'h0});
        lat = 0;
        do begin
            @(negedge clk);
            #2;
            lat++;
        end while (!bus.mem_req_ready && lat < 20);
        chk("t6_accepted", bus.mem_req_ready, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.dcache_re = 1'b0;
        @(negedge clk);
        #2;
        chk("t6_rst_stall", bus.stall, 1'b0);
        chk("t6_rst_dout", bus.dcache_dout, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("t6_late_stall", bus.stall, 1'b0);
        chk("t6_late_req", bus.mem_req_valid, 1'b0);
        do_read(32'h0000_3000, 1'b1, 32'h0000_3000, lat);

        repeat (5) @(negedge clk);
        chk("req_queue_empty", exp_req.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
